// File: rtl/fpall_issue_ctrl.sv
// rtl/fpall_issue_ctrl.sv - FPU issue controller with tag pipeline, credit flow control and in-order result FIFO
package fpall_pkg;
  typedef enum logic [1:0] {
    FP16   = 2'd0,
    BF16   = 2'd1,
    BF16X2 = 2'd2,
    FP32   = 2'd3
  } fp_fmt_e;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_FMA = 2'd3
  } fp_op_e;
endpackage

module fpall_issue_ctrl
  import fpall_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  fp_fmt_e                      in_fmt,
  input  fp_op_e                       in_op,
  input  logic [31:0]                  in_x,
  input  logic [31:0]                  in_y,
  input  logic [TAG_W-1:0]             in_tag,
  output fp_fmt_e                      fpu_fmt,
  output fp_op_e                       fpu_opcode,
  output logic [31:0]                  fpu_x,
  output logic [31:0]                  fpu_y,
  input  logic [31:0]                  fpu_r,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_r,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   run;
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic [LAT-1:0]         sr_vld;
  logic [TAG_W-1:0]       sr_tag [LAT];
  logic [31:0]            r_mem  [DEPTH];
  logic [TAG_W-1:0]       t_mem  [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  // in_ready stays low during reset and rises on the first edge after release;
  // credits come only from registered state, so a same-cycle pop cannot bypass.
  assign in_ready  = run && (outstanding < CNT_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = sr_vld[LAT-1];
  assign out_r     = r_mem[rd_ptr];
  assign out_tag   = t_mem[rd_ptr];

  // Run flag: marks the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // FPU operand registers: load on accept, otherwise hold to avoid toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_fmt    <= FP16;
      fpu_opcode <= OP_MUL;
      fpu_x      <= '0;
      fpu_y      <= '0;
    end else if (accept) begin
      fpu_fmt    <= in_fmt;
      fpu_opcode <= in_op;
      fpu_x      <= in_x;
      fpu_y      <= in_y;
    end
  end

  // Valid+tag shift register tracking each operation through the FPU pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld <= '0;
      for (int i = 0; i < LAT; i++) sr_tag[i] <= '0;
    end else begin
      sr_vld[0] <= accept;
      sr_tag[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
    end
  end

  // Result FIFO storage; the credit limit guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[wr_ptr] <= fpu_r;
      t_mem[wr_ptr] <= sr_tag[LAT-1];
    end
  end

  // FIFO pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outstanding credits: in-flight operations plus FIFO occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// tb/tb_fpall_issue_ctrl.sv - directed and random self-checking bench for fpall_issue_ctrl
module tb_fpall_issue_ctrl;
  import fpall_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  fp_fmt_e           in_fmt;
  fp_op_e            in_op;
  logic [31:0]       in_x, in_y;
  logic [TAG_W-1:0]  in_tag;
  fp_fmt_e           fpu_fmt;
  fp_op_e            fpu_opcode;
  logic [31:0]       fpu_x, fpu_y, fpu_r;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_r;
  logic [TAG_W-1:0]  out_tag;
  logic [$clog2(DEPTH+1)-1:0] outstanding;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]      sb_r [$];
  logic [TAG_W-1:0] sb_t [$];
  logic [31:0]      fpipe [LAT-1];

  always #5 clk = ~clk;

  fpall_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .fpu_fmt(fpu_fmt), .fpu_opcode(fpu_opcode), .fpu_x(fpu_x), .fpu_y(fpu_y),
    .fpu_r(fpu_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag), .outstanding(outstanding)
  );

  // bf16 multiply, round to nearest even, normal operands only
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    logic [6:0]  m;
    logic [9:0]  e;
    logic        g, s;
    logic [7:0]  mr;
    p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
    e = 10'(a[14:7]) + 10'(b[14:7]) - 10'd127;
    if (p[15]) begin
      m = p[14:8]; g = p[7]; s = |p[6:0]; e = e + 10'd1;
    end else begin
      m = p[13:7]; g = p[6]; s = |p[5:0];
    end
    mr = {1'b0, m} + 8'((g && (s || m[0])) ? 1 : 0);
    if (mr[7]) e = e + 10'd1;
    return {a[15] ^ b[15], e[7:0], mr[6:0]};
  endfunction

  function automatic logic [31:0] mul2(input logic [31:0] x, input logic [31:0] y);
    return {bf16_mul(x[31:16], y[31:16]), bf16_mul(x[15:0], y[15:0])};
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  // FPU stand-in: LAT-1 register stages after the operand registers
  always @(posedge clk) begin
    fpipe[0] <= mul2(fpu_x, fpu_y);
    for (int i = 1; i < LAT - 1; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fpu_r = fpipe[LAT-2];

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: score handshakes that the coming edge will perform, then advance.
  task automatic cycle();
    bit acc, pp;
    #1;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp) begin
      check_eq("sb_nonempty", 64'(sb_r.size() != 0), 64'd1);
      if (sb_r.size() != 0) begin
        check_eq("out_r", out_r, sb_r.pop_front());
        check_eq("out_tag", out_tag, sb_t.pop_front());
      end
    end
    if (acc) begin
      sb_r.push_back(mul2(in_x, in_y));
      sb_t.push_back(in_tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
    in_valid = v; in_x = x; in_y = y; in_tag = t;
  endtask

  task automatic drain();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while ((sb_r.size() != 0 || out_valid) && budget < 100) begin
      cycle();
      budget++;
    end
    check_eq("drain_done", 64'(sb_r.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_in_ready"}, in_ready, 0);
    check_eq({pfx, "_out_valid"}, out_valid, 0);
    check_eq({pfx, "_outstanding"}, outstanding, 0);
    check_eq({pfx, "_fpu_x"}, fpu_x, 0);
    check_eq({pfx, "_fpu_y"}, fpu_y, 0);
    check_eq({pfx, "_fpu_fmt"}, fpu_fmt, FP16);
    check_eq({pfx, "_fpu_op"}, fpu_opcode, OP_MUL);
  endtask

  initial begin
    logic [31:0]      hold_r, hold_x;
    logic [TAG_W-1:0] hold_t;
    int               budget;

    rst_n = 1'b0; out_ready = 1'b0; in_fmt = FP16; in_op = OP_MUL;
    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // release reset; in_ready rises only after the next edge
    rst_n = 1'b1;
    #1 check_eq("rel_in_ready_pre", in_ready, 0);
    @(posedge clk); @(negedge clk);
    check_eq("rel_in_ready_post", in_ready, 1);

    // single op, latency LAT+1 posedges including the accept edge
    out_ready = 1'b1;
    drive(1, 32'h3F80_4000, 32'h4000_4040, 4'd3);
    cycle();
    drive(0, 0, 0, 0);
    check_eq("single_fpu_x", fpu_x, 32'h3F80_4000);
    check_eq("single_fpu_y", fpu_y, 32'h4000_4040);
    check_eq("single_outstanding", outstanding, 1);
    check_eq("single_lat_e1", out_valid, 0);
    cycle();
    check_eq("single_lat_e2", out_valid, 0);
    cycle();
    check_eq("single_lat_e3", out_valid, 1);
    check_eq("single_r", out_r, 32'h4000_40C0);
    check_eq("single_tag", out_tag, 3);
    cycle();
    check_eq("single_empty", out_valid, 0);
    check_eq("single_out0", outstanding, 0);

    // burst of 4 with out_ready low; forwarded fmt/opcode
    out_ready = 1'b0;
    in_fmt = BF16X2; in_op = OP_FMA;
    for (int i = 0; i < 4; i++) begin
      drive(1, {rand_bf16(), rand_bf16()}, {rand_bf16(), rand_bf16()}, 4'(i));
      cycle();
    end
    drive(0, 0, 0, 0);
    check_eq("burst_fmt", fpu_fmt, BF16X2);
    check_eq("burst_op", fpu_opcode, OP_FMA);
    check_eq("burst_in_ready", in_ready, 0);
    check_eq("burst_outstanding", outstanding, 4);
    in_op = OP_MUL;
    repeat (LAT) cycle();
    check_eq("burst_head_valid", out_valid, 1);
    check_eq("burst_head_tag", out_tag, 0);

    // backpressure hold for 10 cycles
    hold_r = out_r; hold_t = out_tag; hold_x = fpu_x;
    repeat (10) begin
      cycle();
      check_eq("hold_r", out_r, hold_r);
      check_eq("hold_tag", out_tag, hold_t);
      check_eq("hold_fpu_x", fpu_x, hold_x);
    end
    check_eq("hold_still_full", in_ready, 0);

    // drain in order, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("drain_order", out_tag, 64'(i));
      cycle();
      if (i == 0) begin
        check_eq("drain_in_ready", in_ready, 1);
        check_eq("drain_outstanding", outstanding, 3);
      end
    end
    check_eq("burst_empty", out_valid, 0);

    // outstanding = DEPTH-1, FIFO non-empty, then simultaneous accept+pop
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1, {rand_bf16(), rand_bf16()}, {rand_bf16(), rand_bf16()}, 4'(8 + i));
      cycle();
    end
    drive(0, 0, 0, 0);
    repeat (LAT) cycle();
    check_eq("full_pre_outstanding", outstanding, DEPTH - 1);
    check_eq("full_pre_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1, {rand_bf16(), rand_bf16()}, {rand_bf16(), rand_bf16()}, 4'($urandom_range(0, 15)));
      cycle();
      check_eq("full_outstanding", outstanding, DEPTH - 1);
    end
    drain();

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, {rand_bf16(), rand_bf16()}, {rand_bf16(), rand_bf16()}, 4'(5 + i));
      cycle();
    end
    drive(0, 0, 0, 0);
    cycle();
    rst_n = 1'b0;
    #1 check_reset_vals("async");
    sb_r.delete(); sb_t.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      cycle();
      check_eq("no_stale", out_valid, 0);
    end

    // random bf16x2 traffic
    in_fmt = BF16X2; in_op = OP_MUL;
    begin
      int issued;
      issued = 0;
      budget = 0;
      while (issued < 4000 && budget < 40000) begin
        drive(($urandom_range(0, 3) != 0), {rand_bf16(), rand_bf16()},
              {rand_bf16(), rand_bf16()}, 4'($urandom_range(0, 15)));
        out_ready = ($urandom_range(0, 3) != 0);
        #1 if (in_valid && in_ready) issued++;
        cycle();
        budget++;
      end
      check_eq("rand_issued", 64'(issued), 64'd4000);
    end
    drain();
    check_eq("final_outstanding", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpall_issue_ctrl.md
FPALL_ISSUE_CTRL -- requirements
Module: fpall_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2; the number of clk posedges from operands being driven on fpu_x/fpu_y until fpu_r is valid.
REQ-002 SHALL have parameter DEPTH, default 4; the result FIFO depth and the maximum number of outstanding operations.
REQ-003 SHALL have parameter TAG_W, default 4; the request tag width.
REQ-004 clk  input  1  single clock, all state on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid&in_ready at posedge.
REQ-008 in_fmt  input  fp_fmt_e  operation format.
REQ-009 in_op  input  fp_op_e  opcode.
REQ-010 in_x, in_y  input  32 each  operands.
REQ-011 in_tag  input  TAG_W  request tag, returned with the result.
REQ-012 fpu_fmt  output  fp_fmt_e  registered, drives FPALL_Shared_combine fmt.
REQ-013 fpu_opcode  output  fp_op_e  registered, drives FPU opcode.
REQ-014 fpu_x, fpu_y  output  32 each  registered, drive FPU X/Y.
REQ-015 fpu_r  input  32  FPU result R.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer accepts the result when out_valid&out_ready at posedge.
REQ-018 out_r  output  32  result data.
REQ-019 out_tag  output  TAG_W  tag of out_r.
REQ-020 outstanding  output  $clog2(DEPTH+1)  in-flight count plus FIFO occupancy.

Function
REQ-021 Accept at posedge t: fpu_fmt/fpu_opcode/fpu_x/fpu_y SHALL take the in_* values at t; in_tag SHALL enter stage 0 of a LAT-deep valid+tag shift register.
REQ-022 Without an accept, fpu_* SHALL hold their previous values (no toggling while idle).
REQ-023 The FPU is fully pipelined: back-to-back accepts on consecutive cycles SHALL be supported at one per cycle.
REQ-024 At posedge t+LAT after an accept at t, the module SHALL push {fpu_r, tag} into the FIFO; results SHALL leave the FIFO in issue order.
REQ-025 in_ready SHALL equal (outstanding < DEPTH) computed from registered state; a pop in the same cycle SHALL NOT raise in_ready (no bypass).
REQ-026 Credit rule guarantees no FIFO overflow; a push into a full FIFO SHALL be impossible by construction.
REQ-027 out_valid SHALL be 1 exactly when the FIFO is non-empty; out_r/out_tag SHALL be the FIFO head and SHALL remain stable while out_valid&!out_ready.
REQ-028 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-029 outstanding SHALL increment on accept and decrement on pop; simultaneous accept and pop SHALL leave it unchanged.
REQ-030 FIFO read/write pointers SHALL wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-031 The minimum in_valid-accept to out_valid latency SHALL be LAT+1 posedges (a result pushed at t+LAT is visible after that edge).
REQ-032 in_fmt/in_op values SHALL be forwarded unmodified; the block SHALL NOT interpret the data.

Reset
REQ-033 While rst_n=0: fpu_x=fpu_y=0, fpu_fmt=FP16, fpu_opcode=OP_MUL, shift register valid bits=0, FIFO empty, outstanding=0, out_valid=0, in_ready=0.
REQ-034 in_ready SHALL rise at the first posedge after rst_n deasserts; in-flight operations at reset assertion SHALL be discarded, never emitted.

Verification
REQ-035 Single op: FP16 OP_MUL, X=3F80_4000, Y=4000_4040, tag=3, out_ready=1 -> out_valid exactly LAT+1 posedges after accept, out_r=4000_40C0, out_tag=3.
REQ-036 Burst: 4 back-to-back accepts, tags 0..3, out_ready=0 -> in_ready=0 after the 4th accept, outstanding=4, FIFO holds 4 results; raising out_ready drains tags 0,1,2,3 in order, one per cycle.
REQ-037 Backpressure hold: out_valid=1, out_ready=0 for 10 cycles -> out_r/out_tag unchanged, and fpu_* unchanged without in_valid.
REQ-038 Full, simultaneous accept and pop: outstanding=DEPTH-1 with FIFO non-empty, in_valid=1, out_ready=1 -> accept and pop in the same cycle, outstanding stays DEPTH-1, no data lost over 20 random cycles against an in-order scoreboard.
REQ-039 Reset mid-operation: assert rst_n=0 one cycle after two accepts -> all outputs at REQ-033 values immediately (asynchronously); after release no stale result appears.
REQ-040 Random: 4000 bf16x2 OP_MUL requests with random in_valid/out_ready -> every out_r matches the bf16 RNE reference model for its tag, and the tag order equals the issue order.
